// File: rtl/counter_event_coalescer_if.sv
// counter_event_coalescer_if
//   Bundles the event producers, reinit handshake and counter-side outputs
//   of counter_event_coalescer. Signal names are those of the original
//   flat port list, so existing hookups map one-to-one.
//   Ports (seen from the coalescer, modport slave):
//     inc_ev_valid/inc_ev_amt  in,  inc_ev_ready  out : increment events
//     dec_ev_valid/dec_ev_amt  in,  dec_ev_ready  out : decrement events
//     reinit_req/reinit_val    in,  reinit_ack    out : 4-phase reinit
//     incr_valid/incr, decr_valid/decr           out : counter steps
//     reinit/initial_value                       out : counter reload
//     busy                                       out : work outstanding
//   modport master is the producer/counter side (directions mirrored).
interface counter_event_coalescer_if #(
   parameter int unsigned CNT_W  = 4,
   parameter int unsigned STEP_W = 2,
   parameter int unsigned AMT_W  = 3
);
   logic              inc_ev_valid;
   logic              inc_ev_ready;
   logic [AMT_W-1:0]  inc_ev_amt;
   logic              dec_ev_valid;
   logic              dec_ev_ready;
   logic [AMT_W-1:0]  dec_ev_amt;
   logic              reinit_req;
   logic [CNT_W-1:0]  reinit_val;
   logic              reinit_ack;
   logic              incr_valid;
   logic [STEP_W-1:0] incr;
   logic              decr_valid;
   logic [STEP_W-1:0] decr;
   logic              reinit;
   logic [CNT_W-1:0]  initial_value;
   logic              busy;

   modport slave (
      input  inc_ev_valid, inc_ev_amt, dec_ev_valid, dec_ev_amt,
             reinit_req, reinit_val,
      output inc_ev_ready, dec_ev_ready, reinit_ack,
             incr_valid, incr, decr_valid, decr,
             reinit, initial_value, busy
   );

   modport master (
      output inc_ev_valid, inc_ev_amt, dec_ev_valid, dec_ev_amt,
             reinit_req, reinit_val,
      input  inc_ev_ready, dec_ev_ready, reinit_ack,
             incr_valid, incr, decr_valid, decr,
             reinit, initial_value, busy
   );
endinterface

// File: rtl/counter_event_coalescer.sv
// counter_event_coalescer
//   Upstream feeder for a 4-bit up/down counter. Increment and decrement
//   events are accumulated into pending totals; each cycle at most
//   2^STEP_W-1 counts per direction are emitted on incr/decr. Reinit
//   requests are sequenced RUN -> REINIT (one-cycle reinit pulse) -> ACK
//   (reinit_ack held until reinit_req drops) -> RUN.
//   Ports:
//     clk    in  clock, rising edge
//     rst_n  in  asynchronous active-low reset
//     bus    counter_event_coalescer_if.slave (events, reinit handshake,
//            counter outputs, busy)
//   Options:
//     COALESCER_NET_EN  when defined, opposing counts emitted in the same
//                       cycle are netted against each other; the net
//                       effect on the counter is unchanged.
//   The interface instance must be built with the same CNT_W/STEP_W/AMT_W.
module counter_event_coalescer #(
   parameter int unsigned CNT_W  = 4,
   parameter int unsigned STEP_W = 2,
   parameter int unsigned AMT_W  = 3,
   parameter int unsigned PEND_W = 5
) (
   input logic                     clk,
   input logic                     rst_n,
   counter_event_coalescer_if.slave bus
);

   localparam logic [PEND_W-1:0] STEP_MAX  = PEND_W'((2**STEP_W) - 1);
   // Highest pending level that can still absorb a maximum-size event.
   localparam logic [PEND_W-1:0] READY_LIM =
      PEND_W'(((2**PEND_W) - 1) - ((2**AMT_W) - 1));

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_REINIT = 2'd1,
      ST_ACK    = 2'd2
   } state_t;

   state_t             state;
   logic [PEND_W-1:0]  pend_inc;
   logic [PEND_W-1:0]  pend_dec;
   logic [CNT_W-1:0]   cap_val;

   logic [STEP_W-1:0]  k_i;
   logic [STEP_W-1:0]  k_d;
   logic               acc_i;
   logic               acc_d;

   // Per-cycle emission is capped at STEP_MAX per direction.
   always_comb begin
      k_i = (pend_inc > STEP_MAX) ? STEP_MAX[STEP_W-1:0] : pend_inc[STEP_W-1:0];
      k_d = (pend_dec > STEP_MAX) ? STEP_MAX[STEP_W-1:0] : pend_dec[STEP_W-1:0];
   end

   assign bus.inc_ev_ready = (state == ST_RUN) && !bus.reinit_req && (pend_inc <= READY_LIM);
   assign bus.dec_ev_ready = (state == ST_RUN) && !bus.reinit_req && (pend_dec <= READY_LIM);

   assign acc_i = bus.inc_ev_valid && bus.inc_ev_ready;
   assign acc_d = bus.dec_ev_valid && bus.dec_ev_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_RUN;
         pend_inc <= '0;
         pend_dec <= '0;
         cap_val  <= '0;
      end else begin
         case (state)
            ST_RUN: begin
               pend_inc <= pend_inc - PEND_W'(k_i) + (acc_i ? PEND_W'(bus.inc_ev_amt) : '0);
               pend_dec <= pend_dec - PEND_W'(k_d) + (acc_d ? PEND_W'(bus.dec_ev_amt) : '0);
               if (bus.reinit_req) begin
                  state   <= ST_REINIT;
                  cap_val <= bus.reinit_val;
               end
            end
            ST_REINIT: begin
               pend_inc <= '0;
               pend_dec <= '0;
               state    <= ST_ACK;
            end
            ST_ACK: begin
               if (!bus.reinit_req) state <= ST_RUN;
            end
            default: state <= ST_RUN;
         endcase
      end
   end

   // Outputs decode state and accumulator registers only.
   always_comb begin
      bus.incr_valid    = 1'b0;
      bus.incr          = '0;
      bus.decr_valid    = 1'b0;
      bus.decr          = '0;
      bus.reinit        = 1'b0;
      bus.initial_value = '0;
      bus.reinit_ack    = 1'b0;
      case (state)
         ST_RUN: begin
`ifdef COALESCER_NET_EN
            // Cancel opposing counts; accumulators still drop by k_i/k_d.
            if (k_i < k_d) begin
               bus.decr = k_d - k_i;
            end else begin
               bus.incr = k_i - k_d;
            end
`else
            bus.incr = k_i;
            bus.decr = k_d;
`endif
            bus.incr_valid = (bus.incr != '0);
            bus.decr_valid = (bus.decr != '0);
         end
         ST_REINIT: begin
            bus.reinit        = 1'b1;
            bus.initial_value = cap_val;
         end
         ST_ACK: bus.reinit_ack = 1'b1;
         default: ;
      endcase
   end

   assign bus.busy = (pend_inc != '0) || (pend_dec != '0) || (state != ST_RUN);

endmodule

// File: tb/tb_counter_event_coalescer.sv
// tb_counter_event_coalescer
//   Directed bench for counter_event_coalescer. A behavioural model steps
//   once per clock; expected outputs are queued when stimulus is driven
//   and popped after the clock edge for comparison.
module tb_counter_event_coalescer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   counter_event_coalescer_if #(.CNT_W(4), .STEP_W(2), .AMT_W(3)) bus ();

   counter_event_coalescer #(
      .CNT_W(4), .STEP_W(2), .AMT_W(3), .PEND_W(5)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   typedef struct {
      int iv; int ii; int dv; int dd; int ri; int ivl; int ak; int bz;
   } exp_t;

   exp_t q[$];
   int n_chk = 0;
   int n_fail = 0;

   // model state: 0 RUN, 1 REINIT, 2 ACK
   int m_state = 0;
   int m_pi = 0;
   int m_pd = 0;
   int m_cap = 0;

   task automatic chk(input string tag, input int obs, input int exp_v);
      n_chk++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   function automatic int min3(input int v);
      return (v > 3) ? 3 : v;
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      int ki, kd, m;
      e = '{default: 0};
      if (m_state == 0) begin
         ki = min3(m_pi);
         kd = min3(m_pd);
`ifdef COALESCER_NET_EN
         m = (ki < kd) ? ki : kd;
         ki = ki - m;
         kd = kd - m;
`else
         m = 0;
`endif
         e.ii = ki; e.iv = (ki != 0);
         e.dd = kd; e.dv = (kd != 0);
      end else if (m_state == 1) begin
         e.ri = 1; e.ivl = m_cap;
      end else begin
         e.ak = 1;
      end
      e.bz = (m_pi != 0 || m_pd != 0 || m_state != 0);
      return e;
   endfunction

   function automatic int model_ready(input int pend, input int rq);
      return (m_state == 0 && rq == 0 && pend <= 24) ? 1 : 0;
   endfunction

   task automatic model_reset();
      m_state = 0; m_pi = 0; m_pd = 0; m_cap = 0;
      q.delete();
   endtask

   // One clock: drive at negedge, check readies, advance model, check
   // outputs of the following cycle. Returns the observed inc_ev_ready.
   task automatic step(input int iv, input int ia, input int dv, input int da,
                       input int rq, input int rv, output int rdy_i);
      exp_t e;
      int ei, ed, ki, kd;
      bus.inc_ev_valid = iv[0];
      bus.inc_ev_amt   = 3'(ia);
      bus.dec_ev_valid = dv[0];
      bus.dec_ev_amt   = 3'(da);
      bus.reinit_req   = rq[0];
      bus.reinit_val   = 4'(rv);
      #1;
      ei = model_ready(m_pi, rq);
      ed = model_ready(m_pd, rq);
      rdy_i = int'(bus.inc_ev_ready);
      chk("inc_ev_ready", int'(bus.inc_ev_ready), ei);
      chk("dec_ev_ready", int'(bus.dec_ev_ready), ed);
      case (m_state)
         0: begin
            ki = min3(m_pi);
            kd = min3(m_pd);
            m_pi = m_pi - ki + ((iv != 0 && ei != 0) ? ia : 0);
            m_pd = m_pd - kd + ((dv != 0 && ed != 0) ? da : 0);
            if (rq != 0) begin m_state = 1; m_cap = rv; end
         end
         1: begin m_pi = 0; m_pd = 0; m_state = 2; end
         default: if (rq == 0) m_state = 0;
      endcase
      q.push_back(model_out());
      @(posedge clk);
      #1;
      e = q.pop_front();
      chk("incr_valid",    int'(bus.incr_valid),    e.iv);
      chk("incr",          int'(bus.incr),          e.ii);
      chk("decr_valid",    int'(bus.decr_valid),    e.dv);
      chk("decr",          int'(bus.decr),          e.dd);
      chk("reinit",        int'(bus.reinit),        e.ri);
      chk("initial_value", int'(bus.initial_value), e.ivl);
      chk("reinit_ack",    int'(bus.reinit_ack),    e.ak);
      chk("busy",          int'(bus.busy),          e.bz);
      @(negedge clk);
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_incr_valid"}, int'(bus.incr_valid), 0);
      chk({tag, "_incr"},       int'(bus.incr), 0);
      chk({tag, "_decr_valid"}, int'(bus.decr_valid), 0);
      chk({tag, "_decr"},       int'(bus.decr), 0);
      chk({tag, "_reinit"},     int'(bus.reinit), 0);
      chk({tag, "_init_val"},   int'(bus.initial_value), 0);
      chk({tag, "_ack"},        int'(bus.reinit_ack), 0);
      chk({tag, "_busy"},       int'(bus.busy), 0);
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      #1;
      chk_zero_outputs(tag);
      model_reset();
      bus.inc_ev_valid = 1'b0;
      bus.dec_ev_valid = 1'b0;
      bus.reinit_req   = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk({tag, "_rel_inc_ready"}, int'(bus.inc_ev_ready), 1);
      chk({tag, "_rel_dec_ready"}, int'(bus.dec_ev_ready), 1);
      chk({tag, "_rel_busy"},      int'(bus.busy), 0);
      @(negedge clk);
   endtask

   initial begin : stim
      int r;
      bus.inc_ev_valid = 1'b0;
      bus.inc_ev_amt   = '0;
      bus.dec_ev_valid = 1'b0;
      bus.dec_ev_amt   = '0;
      bus.reinit_req   = 1'b0;
      bus.reinit_val   = '0;
      @(negedge clk);

      // Power-on reset, then reset mid-traffic.
      do_reset("por");
      step(1, 7, 1, 5, 0, 0, r);
      step(1, 6, 1, 4, 0, 0, r);
      do_reset("midrst");

      // Single increment of 3.
      step(1, 3, 0, 0, 0, 0, r);
      chk("t2_incr_valid", int'(bus.incr_valid), 1);
      chk("t2_incr", int'(bus.incr), 3);
      step(0, 0, 0, 0, 0, 0, r);
      chk("t2_idle_valid", int'(bus.incr_valid), 0);
      chk("t2_idle_busy", int'(bus.busy), 0);

      // Saturating increment stream: ready drops at pending 27.
      for (int c = 0; c < 8; c++) begin
         step(1, 7, 0, 0, 0, 0, r);
         chk("t3_incr", int'(bus.incr), 3);
         if (c == 6) chk("t3_ready_c6", r, 0);
         if (c == 7) chk("t3_ready_c7", r, 1);
      end
      for (int c = 0; c < 12; c++) step(0, 0, 0, 0, 0, 0, r);
      chk("t3_drained_busy", int'(bus.busy), 0);

      // Simultaneous inc 3 and dec 2.
      step(1, 3, 1, 2, 0, 0, r);
`ifdef COALESCER_NET_EN
      chk("t4_net_incr", int'(bus.incr), 1);
      chk("t4_net_decr_valid", int'(bus.decr_valid), 0);
`else
      chk("t4_incr", int'(bus.incr), 3);
      chk("t4_decr", int'(bus.decr), 2);
      chk("t4_decr_valid", int'(bus.decr_valid), 1);
`endif
      step(0, 0, 0, 0, 0, 0, r);
      step(0, 0, 0, 0, 0, 0, r);

      // Reinit with pending_inc = 10.
      step(1, 7, 0, 0, 0, 0, r);
      step(1, 6, 0, 0, 0, 0, r);
      step(1, 5, 1, 5, 1, 9, r);
      chk("t5_reinit", int'(bus.reinit), 1);
      chk("t5_initial_value", int'(bus.initial_value), 9);
      chk("t5_no_incr", int'(bus.incr_valid), 0);
      for (int c = 0; c < 3; c++) begin
         step(1, 4, 1, 4, 1, 0, r);
         chk("t5_ack", int'(bus.reinit_ack), 1);
      end
      step(0, 0, 0, 0, 0, 0, r);
      chk("t5_ack_drop", int'(bus.reinit_ack), 0);
      chk("t5_pending_clear", int'(bus.busy), 0);

      // Reset during ACK.
      step(1, 7, 0, 0, 1, 5, r);
      step(0, 0, 0, 0, 1, 5, r);
      chk("t6_in_ack", int'(bus.reinit_ack), 1);
      do_reset("t6");
      step(0, 0, 0, 0, 0, 0, r);
      chk("t6_no_stale_incr", int'(bus.incr_valid), 0);
      chk("t6_no_stale_busy", int'(bus.busy), 0);

      // Random mixed traffic.
      for (int c = 0; c < 60; c++) begin
         step(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 0, 0, r);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
